// File: rtl/pb_pkg.sv
// Shared types and helpers for the pushbutton conditioner.
package pb_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } pb_state_t;

    // Width needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button: metastability synchroniser, debounce FSM, long-press counter
// and registered one-cycle event pulses.
module pb_channel
    import pb_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int LONG_TICKS     = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb,
    output logic held,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int DW = cnt_width(DEBOUNCE_TICKS);
    localparam int LW = cnt_width(LONG_TICKS);
    localparam logic IDLE_LEVEL = ACTIVE_LOW;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [LW-1:0] L_MAX  = LW'(LONG_TICKS);
    localparam logic [LW-1:0] L_ONE  = LW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    pb_state_t              state;
    logic [DW-1:0]          dcnt;
    logic [LW-1:0]          lcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
    end

    // Any departure from the idle pin level means "pressed".
    assign s = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RELEASED;
            dcnt       <= '0;
            lcnt       <= '0;
            held       <= 1'b0;
            pressed    <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
        end else begin
            // Pulses clear every clock, tick or not, so they stay one clock wide.
            pressed    <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
            if (tick) begin
                case (state)
                    RELEASED: begin
                        if (s) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state   <= HELD;
                                held    <= 1'b1;
                                pressed <= 1'b1;
                                lcnt    <= '0;
                                dcnt    <= '0;
                            end else begin
                                state <= PRESS_PEND;
                                dcnt  <= D_ONE;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!s) begin
                            state <= RELEASED;
                            dcnt  <= '0;
                        end else if (dcnt + D_ONE == D_LAST) begin
                            state   <= HELD;
                            held    <= 1'b1;
                            pressed <= 1'b1;
                            lcnt    <= '0;
                            dcnt    <= '0;
                        end else begin
                            dcnt <= dcnt + D_ONE;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state    <= RELEASED;
                                held     <= 1'b0;
                                released <= 1'b1;
                                dcnt     <= '0;
                            end else begin
                                state <= RELEASE_PEND;
                                dcnt  <= D_ONE;
                            end
                        end else if (LONG_TICKS != 0 && lcnt != L_MAX) begin
                            lcnt <= lcnt + L_ONE;
                            if (lcnt + L_ONE == L_MAX) long_press <= 1'b1;
                        end
                    end
                    RELEASE_PEND: begin
                        // A bounce back to pressed keeps lcnt, so the long-press timer survives glitches.
                        if (s) begin
                            state <= HELD;
                            dcnt  <= '0;
                        end else if (dcnt + D_ONE == D_LAST) begin
                            state    <= RELEASED;
                            held     <= 1'b0;
                            released <= 1'b1;
                            dcnt     <= '0;
                        end else begin
                            dcnt <= dcnt + D_ONE;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end
    end

endmodule

// File: rtl/pb_debounce_multi.sv
// N-channel pushbutton conditioner: fans the pins out to independent
// pb_channel instances and gathers their outputs.
module pb_debounce_multi #(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int LONG_TICKS     = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pb_debounce_multi: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_deb
        $error("pb_debounce_multi: DEBOUNCE_TICKS must be >= 1");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("pb_debounce_multi: N_CH must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .pb        (PB[i]),
            .held      (held[i]),
            .pressed   (pressed[i]),
            .released  (released[i]),
            .long_press(long_press[i])
        );
    end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Self-checking bench for pb_debounce_multi: pulse scoreboard keyed on clock
// count, a glitch-length vector table and hand-written multi-cycle sequences.
module tb_pb_debounce_multi;

    localparam int N_CH = 2;
    localparam int SYNC = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] pb;
    logic [1:0] held, pressed, released, long_press;

    int   cyc = 0;
    logic tick_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int   low;
        logic exp_press;
    } vec_t;
    vec_t tbl[5];

    pb_debounce_multi #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS(LONG), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .PB(pb),
        .held(held), .pressed(pressed), .released(released), .long_press(long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // In divided mode the tick is high on edges whose number is a multiple of 4.
    assign tick = tick_mode ? (cyc % 4 == 3) : 1'b1;

    function automatic void expect_pulse(input int c, input logic [1:0] pr,
                                         input logic [1:0] rl, input logic [1:0] lp);
        exp_t e;
        e.cyc = c;
        e.vec = {pr, rl, lp};
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == c) begin
                sb[i].vec = sb[i].vec | e.vec;
                return;
            end
            if (sb[i].cyc > c) begin
                sb.insert(i, e);
                return;
            end
        end
        sb.push_back(e);
    endfunction

    // Edge at which a level change driven after edge k commits: the synchroniser
    // needs SYNC edges, then DEB ticked edges must see the new level.
    function automatic int commit_cycle(input int k);
        int e = k + SYNC;
        int n = 0;
        while (n < DEB) begin
            e++;
            if (!tick_mode || (e % 4 == 0)) n++;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        logic [5:0] obs;
        if (!rst) begin
            obs = {pressed, released, long_press};
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed_pulse: expected %b at clk %0d, nothing matched", sb[0].vec, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                checks++;
                if (obs !== sb[0].vec) begin
                    errors++;
                    $display("[TB] FAIL pulse_at_%0d: got {pr,rl,lp}=%b expected %b", cyc, obs, sb[0].vec);
                end
                void'(sb.pop_front());
            end else if (obs !== 6'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse_at_%0d: got {pr,rl,lp}=%b expected 000000", cyc, obs);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (clk %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, output int at);
        pb = v;
        at = cyc;
    endtask

    initial begin
        int k, r, p, g;

        tbl[0] = '{low: 1, exp_press: 1'b0};
        tbl[1] = '{low: 2, exp_press: 1'b0};
        tbl[2] = '{low: 3, exp_press: 1'b0};
        tbl[3] = '{low: 4, exp_press: 1'b1};
        tbl[4] = '{low: 6, exp_press: 1'b1};

        rst = 1'b1;
        pb  = 2'b11;
        @(posedge clk);
        #1;
        go(3);
        checkOutput("reset_outputs", {held, pressed, released, long_press}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            go(cyc + 10);
            checkOutput("idle_after_reset", {held, pressed, released, long_press}, 8'h00);
        end

        $display("[TB] press and hold channel 0");
        applyStimulus(2'b10, k);
        p = commit_cycle(k);
        expect_pulse(p, 2'b01, 2'b00, 2'b00);
        expect_pulse(p + LONG, 2'b00, 2'b00, 2'b01);
        go(p);
        checkOutput("press_latency", 8'(p - k), 8'(SYNC + DEB));
        checkOutput("held_after_press", {6'b0, held}, 8'h01);
        go(k + 30);
        applyStimulus(2'b11, r);
        expect_pulse(commit_cycle(r), 2'b00, 2'b01, 2'b00);
        go(r + 12);
        checkOutput("held_after_release", {6'b0, held}, 8'h00);

        $display("[TB] glitch length table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b10, k);
            if (tbl[i].exp_press) expect_pulse(commit_cycle(k), 2'b01, 2'b00, 2'b00);
            go(k + tbl[i].low);
            applyStimulus(2'b11, r);
            if (tbl[i].exp_press) expect_pulse(commit_cycle(r), 2'b00, 2'b01, 2'b00);
            go(k + SYNC + DEB);
            checkOutput($sformatf("held_low%0d", tbl[i].low), {6'b0, held}, {7'b0, tbl[i].exp_press});
            go(k + tbl[i].low + 12);
            checkOutput($sformatf("settled_low%0d", tbl[i].low), {6'b0, held}, 8'h00);
        end

        $display("[TB] release glitch during hold");
        applyStimulus(2'b10, k);
        expect_pulse(commit_cycle(k), 2'b01, 2'b00, 2'b00);
        go(k + 12);
        applyStimulus(2'b11, g);
        go(g + 2);
        applyStimulus(2'b10, g);
        go(g + 8);
        checkOutput("held_through_glitch", {6'b0, held}, 8'h01);
        applyStimulus(2'b11, r);
        expect_pulse(commit_cycle(r), 2'b00, 2'b01, 2'b00);
        go(r + 12);

        $display("[TB] two channels");
        applyStimulus(2'b00, k);
        p = commit_cycle(k);
        expect_pulse(p, 2'b11, 2'b00, 2'b00);
        expect_pulse(p + LONG, 2'b00, 2'b00, 2'b01);
        go(k + 10);
        applyStimulus(2'b10, r);
        expect_pulse(commit_cycle(r), 2'b00, 2'b10, 2'b00);
        go(r + 12);
        checkOutput("held_ch0_only", {6'b0, held}, 8'h01);
        go(k + 30);
        applyStimulus(2'b11, r);
        expect_pulse(commit_cycle(r), 2'b00, 2'b01, 2'b00);
        go(r + 12);

        $display("[TB] divided tick");
        tick_mode = 1'b1;
        go(cyc + 3);
        applyStimulus(2'b10, k);
        p = commit_cycle(k);
        expect_pulse(p, 2'b01, 2'b00, 2'b00);
        go(p + 1);
        checkOutput("held_slow_tick", {6'b0, held}, 8'h01);
        go(p + 10);
        applyStimulus(2'b11, r);
        p = commit_cycle(r);
        expect_pulse(p, 2'b00, 2'b01, 2'b00);
        go(p + 8);
        tick_mode = 1'b0;
        go(cyc + 4);

        $display("[TB] reset while held");
        applyStimulus(2'b10, k);
        expect_pulse(commit_cycle(k), 2'b01, 2'b00, 2'b00);
        go(k + 12);
        checkOutput("held_before_reset", {6'b0, held}, 8'h01);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("held_cleared_by_reset", {6'b0, held}, 8'h00);
        pb = 2'b11;
        @(posedge clk);
        #1;
        go(cyc + 3);
        rst = 1'b0;
        go(cyc + 25);
        checkOutput("quiet_after_reset", {held, pressed, released, long_press}, 8'h00);

        go(cyc + 5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
